exu_dtcm_arb: RTL and testbench

//  Two-master arbiter in front of the single-port DTCM SRAM. Master 0 is the EXU AGU/LSU command path;

---
 rtl/exu_dtcm_arb_pkg.sv | 19 +
 rtl/exu_dtcm_arb_rspfifo.sv | 51 +++++
 rtl/exu_dtcm_arb.sv | 186 ++++++++++++++++++
 tb/tb_exu_dtcm_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_dtcm_arb_pkg.sv
// Shared types and default sizes for the DTCM two-master arbiter.
// The round-robin policy is selected by defining DTCM_ARB_RR_EN.
package exu_dtcm_arb_pkg;

    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int XLEN            = 32;
    localparam int DTCM_ARB_OUTS   = 2;

    typedef enum logic {
        ARB_ID_AGU = 1'b0,
        ARB_ID_BUS = 1'b1
    } arb_id_e;

    // Counter width able to hold 0..depth inclusive (depth is a power of 2).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/exu_dtcm_arb_rspfifo.sv
// Response FIFO of {master id, data}. The pointers carry an extra phase bit,
// so full and empty are distinguished without a separate occupancy counter.
module exu_dtcm_arb_rspfifo
    import exu_dtcm_arb_pkg::*;
#(
    parameter int DW    = XLEN,
    parameter int DEPTH = DTCM_ARB_OUTS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  arb_id_e       push_id,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output arb_id_e       head_id,
    output logic [DW-1:0] head_data,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);

    arb_id_e       mem_id   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_id   = mem_id[rd_ptr[PW-1:0]];
    assign head_data = mem_data[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr[PW-1:0]]   <= push_id;
            mem_data[wr_ptr[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/exu_dtcm_arb.sv
// Two-master arbiter in front of the single-port DTCM SRAM with credit-bounded,
// in-order responses. Define DTCM_ARB_RR_EN for round-robin, else m0 has priority.
module exu_dtcm_arb
    import exu_dtcm_arb_pkg::*;
#(
    parameter int AW         = DTCM_ADDR_WIDTH,
    parameter int DW         = XLEN,
    parameter int OUTS_DEPTH = DTCM_ARB_OUTS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cmd_valid,
    output logic            m0_cmd_ready,
    input  logic [AW-1:0]   m0_cmd_addr,
    input  logic            m0_cmd_read,
    input  logic [DW-1:0]   m0_cmd_wdata,
    input  logic [DW/8-1:0] m0_cmd_wmask,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [DW-1:0]   m0_rsp_rdata,
    input  logic            m1_cmd_valid,
    output logic            m1_cmd_ready,
    input  logic [AW-1:0]   m1_cmd_addr,
    input  logic            m1_cmd_read,
    input  logic [DW-1:0]   m1_cmd_wdata,
    input  logic [DW/8-1:0] m1_cmd_wmask,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [DW-1:0]   m1_rsp_rdata,
    output logic            ram_cs,
    output logic            ram_we,
    output logic [AW-3:0]   ram_addr,
    output logic [DW/8-1:0] ram_wem,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    // Handshake rule: a command transfers when cmd_valid && cmd_ready, a response
    // when rsp_valid && rsp_ready; valid never waits on ready, and response data
    // stays stable while valid is held without ready.

    localparam int CW = cnt_width(OUTS_DEPTH);

    logic          credit_ok;
    logic          grant_0;
    logic          grant_1;
    logic          grant_any;
    logic [CW-1:0] outs_cnt;

    logic          rd_pend;
    logic          rd_isrd;
    arb_id_e       rd_id;
    logic [DW-1:0] rsp_data;

    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    arb_id_e       head_id;
    logic [DW-1:0] head_data;

    logic          out_valid;
    logic          out_ready;
    arb_id_e       out_id;
    logic [DW-1:0] out_data;
    logic          rsp_hs;
    logic          sel_read;

    // Gating with rst_n keeps the SRAM deselected while reset is held.
    assign credit_ok = rst_n && (outs_cnt < CW'(OUTS_DEPTH));

`ifdef DTCM_ARB_RR_EN
    arb_id_e rr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rr_last <= ARB_ID_BUS;
        else if (grant_any) rr_last <= grant_1 ? ARB_ID_BUS : ARB_ID_AGU;
    end
`endif

    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (credit_ok) begin
            if (m0_cmd_valid && m1_cmd_valid) begin
`ifdef DTCM_ARB_RR_EN
                if (rr_last == ARB_ID_AGU) grant_1 = 1'b1;
                else                       grant_0 = 1'b1;
`else
                grant_0 = 1'b1;
`endif
            end else begin
                grant_0 = m0_cmd_valid;
                grant_1 = m1_cmd_valid;
            end
        end
    end

    assign grant_any    = grant_0 || grant_1;
    assign m0_cmd_ready = grant_0;
    assign m1_cmd_ready = grant_1;

    assign sel_read = grant_1 ? m1_cmd_read : m0_cmd_read;
    assign ram_cs   = grant_any;
    assign ram_we   = grant_any && !sel_read;
    assign ram_addr = grant_1 ? m1_cmd_addr[AW-1:2] : m0_cmd_addr[AW-1:2];
    assign ram_wem  = grant_1 ? m1_cmd_wmask : m0_cmd_wmask;
    assign ram_din  = grant_1 ? m1_cmd_wdata : m0_cmd_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_isrd <= 1'b0;
            rd_id   <= ARB_ID_AGU;
        end else begin
            rd_pend <= grant_any;
            if (grant_any) begin
                rd_isrd <= sel_read;
                rd_id   <= grant_1 ? ARB_ID_BUS : ARB_ID_AGU;
            end
        end
    end

    assign rsp_data = rd_isrd ? ram_dout : '0;

    // The FIFO head always has precedence; the SRAM result bypasses only when
    // nothing older is queued, which keeps responses globally in order.
    always_comb begin
        out_valid = 1'b0;
        out_id    = ARB_ID_AGU;
        out_data  = '0;
        if (!fifo_empty) begin
            out_valid = 1'b1;
            out_id    = head_id;
            out_data  = head_data;
        end else if (rd_pend) begin
            out_valid = 1'b1;
            out_id    = rd_id;
            out_data  = rsp_data;
        end
    end

    assign out_ready = (out_id == ARB_ID_BUS) ? m1_rsp_ready : m0_rsp_ready;
    assign rsp_hs    = out_valid && out_ready;
    assign fifo_pop  = rsp_hs && !fifo_empty;
    assign fifo_push = rd_pend && !(fifo_empty && rsp_hs);

    assign m0_rsp_valid = out_valid && (out_id == ARB_ID_AGU);
    assign m1_rsp_valid = out_valid && (out_id == ARB_ID_BUS);
    assign m0_rsp_rdata = (out_id == ARB_ID_AGU) ? out_data : '0;
    assign m1_rsp_rdata = (out_id == ARB_ID_BUS) ? out_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs_cnt <= '0;
        end else begin
            case ({grant_any, rsp_hs})
                2'b10:   outs_cnt <= outs_cnt + CW'(1);
                2'b01:   outs_cnt <= outs_cnt - CW'(1);
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

    exu_dtcm_arb_rspfifo #(
        .DW    (DW),
        .DEPTH (OUTS_DEPTH)
    ) u_rspfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_id   (rd_id),
        .push_data (rsp_data),
        .pop       (fifo_pop),
        .head_id   (head_id),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Byte-offset bits never reach the word-addressed SRAM; the credit counter
    // already makes the full flag redundant here.
    logic unused_ok;
    assign unused_ok = ^{m0_cmd_addr[1:0], m1_cmd_addr[1:0], fifo_full};

endmodule

// File: tb/tb_exu_dtcm_arb.sv
// Directed bench for exu_dtcm_arb; expectations follow DTCM_ARB_RR_EN when defined.
module tb_exu_dtcm_arb;

    logic        clk;
    logic        rst_n;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
    logic [15:0] m0_cmd_addr;
    logic [31:0] m0_cmd_wdata;
    logic [3:0]  m0_cmd_wmask;
    logic        m0_rsp_valid, m0_rsp_ready;
    logic [31:0] m0_rsp_rdata;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
    logic [15:0] m1_cmd_addr;
    logic [31:0] m1_cmd_wdata;
    logic [3:0]  m1_cmd_wmask;
    logic        m1_rsp_valid, m1_rsp_ready;
    logic [31:0] m1_rsp_rdata;
    logic        ram_cs, ram_we;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int n_run;
    int n_fail;

    exu_dtcm_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_cmd_valid (m0_cmd_valid),
        .m0_cmd_ready (m0_cmd_ready),
        .m0_cmd_addr  (m0_cmd_addr),
        .m0_cmd_read  (m0_cmd_read),
        .m0_cmd_wdata (m0_cmd_wdata),
        .m0_cmd_wmask (m0_cmd_wmask),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_cmd_valid (m1_cmd_valid),
        .m1_cmd_ready (m1_cmd_ready),
        .m1_cmd_addr  (m1_cmd_addr),
        .m1_cmd_read  (m1_cmd_read),
        .m1_cmd_wdata (m1_cmd_wdata),
        .m1_cmd_wmask (m1_cmd_wmask),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_rdata (m1_rsp_rdata),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wem      (ram_wem),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, exp finish before 100000");
        $fatal(1, "watchdog");
    end

    // SRAM model: word 0x0004 holds 0xDEADBEEF, every other word reads 0x5A5A0000 ^ word.
    always @(posedge clk) begin
        if (ram_cs && !ram_we)
            ram_dout <= (ram_addr == 14'h0004) ? 32'hDEADBEEF : (32'h5A5A0000 ^ {18'h0, ram_addr});
    end

    // Driver tasks
    task automatic idle_inputs();
        m0_cmd_valid = 1'b0; m0_cmd_read = 1'b1; m0_cmd_addr = '0; m0_cmd_wdata = '0; m0_cmd_wmask = '0;
        m1_cmd_valid = 1'b0; m1_cmd_read = 1'b1; m1_cmd_addr = '0; m1_cmd_wdata = '0; m1_cmd_wmask = '0;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ram_dout = '0;
        idle_inputs();
        m0_cmd_valid = 1'b1;
        #12;
        n_run++; if (ram_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b exp 0", ram_cs); end
        n_run++; if (m0_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b exp 0", m0_cmd_ready); end
        n_run++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 00", {m0_rsp_valid, m1_rsp_valid}); end
        n_run++; if (dut.outs_cnt !== '0) begin n_fail++; $display("FAIL reset_outs_cnt: got %0d exp 0", dut.outs_cnt); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = 16'h0010;
        #1;
        n_run++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_cmd_ready: got %b exp 1", m0_cmd_ready); end
        n_run++; if ({ram_cs, ram_we} !== 2'b10) begin n_fail++; $display("FAIL rd_cs_we: got %b exp 10", {ram_cs, ram_we}); end
        n_run++; if (ram_addr !== 14'h0004) begin n_fail++; $display("FAIL rd_ram_addr: got %h exp 0004", ram_addr); end
        @(negedge clk);
        m0_cmd_valid = 1'b0;
        #1;
        n_run++; if (m0_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %b exp 1", m0_rsp_valid); end
        n_run++; if (m0_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp_rdata: got %h exp deadbeef", m0_rsp_rdata); end
        n_run++; if (m1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_m1_quiet: got %b exp 0", m1_rsp_valid); end
        @(negedge clk);
        n_run++; if (m0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_done: got %b exp 0", m0_rsp_valid); end
        n_run++; if (dut.outs_cnt !== '0) begin n_fail++; $display("FAIL rd_outs_cnt: got %0d exp 0", dut.outs_cnt); end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_g1;
`ifdef DTCM_ARB_RR_EN
        exp_g1 = 4'b1010;   // cycle 0 is bit 0: m1, m0, m1, m0 (m0 won last)
        exp_g1 = {exp_g1[0], exp_g1[1], exp_g1[2], exp_g1[3]};
`else
        exp_g1 = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = 16'h0100 + 16'(k * 4);
            m1_cmd_valid = 1'b1; m1_cmd_read = 1'b1; m1_cmd_addr = 16'h0200 + 16'(k * 4);
            #1;
            n_run++; if ({m1_cmd_ready, m0_cmd_ready} !== {exp_g1[k], !exp_g1[k]}) begin n_fail++; $display("FAIL arb_grant[%0d]: got m1/m0 %b exp %b", k, {m1_cmd_ready, m0_cmd_ready}, {exp_g1[k], !exp_g1[k]}); end
            if (k > 0) begin
                n_run++; if ({m1_rsp_valid, m0_rsp_valid} !== {exp_g1[k-1], !exp_g1[k-1]}) begin n_fail++; $display("FAIL arb_rsp[%0d]: got m1/m0 %b exp %b", k, {m1_rsp_valid, m0_rsp_valid}, {exp_g1[k-1], !exp_g1[k-1]}); end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_run++; if ({m1_rsp_valid, m0_rsp_valid} !== {exp_g1[3], !exp_g1[3]}) begin n_fail++; $display("FAIL arb_rsp_last: got m1/m0 %b exp %b", {m1_rsp_valid, m0_rsp_valid}, {exp_g1[3], !exp_g1[3]}); end
        @(negedge clk);
        n_run++; if (dut.outs_cnt !== '0) begin n_fail++; $display("FAIL arb_outs_cnt: got %0d exp 0", dut.outs_cnt); end
    endtask

    task automatic test_credit_stall();
        @(negedge clk);
        m0_rsp_ready = 1'b0;
        m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = 16'h0020;
        #1;
        n_run++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cr_first: got %b exp 1", m0_cmd_ready); end
        @(negedge clk);
        m0_cmd_addr = 16'h0024;
        #1;
        n_run++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cr_second: got %b exp 1", m0_cmd_ready); end
        @(negedge clk);
        m0_cmd_addr = 16'h0028;
        #1;
        n_run++; if (m0_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cr_third_blocked: got %b exp 0", m0_cmd_ready); end
        n_run++; if (m0_rsp_rdata !== 32'h5A5A0008) begin n_fail++; $display("FAIL cr_head: got %h exp 5a5a0008", m0_rsp_rdata); end
        @(negedge clk);
        #1;
        n_run++; if (m0_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cr_still_blocked: got %b exp 0", m0_cmd_ready); end
        n_run++; if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'h5A5A0008}) begin n_fail++; $display("FAIL cr_hold: got %b/%h exp 1/5a5a0008", m0_rsp_valid, m0_rsp_rdata); end
        @(negedge clk);
        m0_rsp_ready = 1'b1;
        #1;
        n_run++; if (m0_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cr_full_pop: got %b exp 0", m0_cmd_ready); end
        @(negedge clk);
        #1;
        n_run++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cr_third_grant: got %b exp 1", m0_cmd_ready); end
        n_run++; if (m0_rsp_rdata !== 32'h5A5A0009) begin n_fail++; $display("FAIL cr_second_data: got %h exp 5a5a0009", m0_rsp_rdata); end
        @(negedge clk);
        m0_cmd_valid = 1'b0;
        #1;
        n_run++; if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'h5A5A000A}) begin n_fail++; $display("FAIL cr_third_data: got %b/%h exp 1/5a5a000a", m0_rsp_valid, m0_rsp_rdata); end
        @(negedge clk);
        n_run++; if ({m0_rsp_valid, dut.outs_cnt} !== '0) begin n_fail++; $display("FAIL cr_drained: got valid %b cnt %0d exp 0 0", m0_rsp_valid, dut.outs_cnt); end
    endtask

    task automatic test_hol_blocking();
        @(negedge clk);
        m1_rsp_ready = 1'b0;
        m1_cmd_valid = 1'b1; m1_cmd_read = 1'b1; m1_cmd_addr = 16'h0040;
        #1;
        n_run++; if (m1_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hol_m1_grant: got %b exp 1", m1_cmd_ready); end
        @(negedge clk);
        m1_cmd_valid = 1'b0;
        m0_cmd_valid = 1'b1; m0_cmd_read = 1'b0; m0_cmd_addr = 16'h0050;
        m0_cmd_wdata = 32'hAAAA5555; m0_cmd_wmask = 4'hF;
        #1;
        n_run++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL hol_m0_grant: got %b exp 1", m0_cmd_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m0_cmd_valid = 1'b0;
            #1;
            n_run++; if ({m1_rsp_valid, m0_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL hol_blocked[%0d]: got m1/m0 %b exp 10", k, {m1_rsp_valid, m0_rsp_valid}); end
        end
        @(negedge clk);
        m1_rsp_ready = 1'b1;
        #1;
        n_run++; if ({m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid} !== {1'b1, 32'h5A5A0010, 1'b0}) begin n_fail++; $display("FAIL hol_m1_rsp: got %b/%h/%b exp 1/5a5a0010/0", m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid); end
        @(negedge clk);
        #1;
        n_run++; if ({m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL hol_m0_rsp: got %b/%h/%b exp 1/00000000/0", m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid); end
        @(negedge clk);
        n_run++; if ({m0_rsp_valid, m1_rsp_valid, dut.outs_cnt} !== '0) begin n_fail++; $display("FAIL hol_drained: got %b %b cnt %0d exp 0 0 0", m0_rsp_valid, m1_rsp_valid, dut.outs_cnt); end
        idle_inputs();
    endtask

    task automatic test_write();
        @(negedge clk);
        m0_cmd_valid = 1'b1; m0_cmd_read = 1'b0; m0_cmd_addr = 16'h0008;
        m0_cmd_wdata = 32'h12345678; m0_cmd_wmask = 4'b0011;
        #1;
        n_run++; if ({ram_cs, ram_we, ram_wem} !== 6'b11_0011) begin n_fail++; $display("FAIL wr_ctrl: got cs%b we%b wem%b exp 1 1 0011", ram_cs, ram_we, ram_wem); end
        n_run++; if ({ram_addr, ram_din} !== {14'h0002, 32'h12345678}) begin n_fail++; $display("FAIL wr_addr_data: got %h/%h exp 0002/12345678", ram_addr, ram_din); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_run++; if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wr_rsp: got %b/%h exp 1/00000000", m0_rsp_valid, m0_rsp_rdata); end
        @(negedge clk);
        n_run++; if (m0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_single_rsp: got %b exp 0", m0_rsp_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m0_rsp_ready = 1'b0;
        m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = 16'h0030;
        @(negedge clk);
        m0_cmd_addr = 16'h0034;
        @(negedge clk);
        m0_cmd_valid = 1'b0;
        #1;
        n_run++; if ({m0_rsp_valid, dut.outs_cnt} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL rm_before: got valid %b cnt %0d exp 1 2", m0_rsp_valid, dut.outs_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_run++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rm_rsp_valid: got %b exp 00", {m0_rsp_valid, m1_rsp_valid}); end
        n_run++; if (dut.outs_cnt !== '0) begin n_fail++; $display("FAIL rm_outs_cnt: got %0d exp 0", dut.outs_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        m0_rsp_ready = 1'b1;
        @(negedge clk);
        m0_cmd_valid = 1'b1; m0_cmd_read = 1'b1; m0_cmd_addr = 16'h0010;
        #1;
        n_run++; if (m0_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_fresh_grant: got %b exp 1", m0_cmd_ready); end
        @(negedge clk);
        m0_cmd_valid = 1'b0;
        #1;
        n_run++; if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rm_fresh_rsp: got %b/%h exp 1/deadbeef", m0_rsp_valid, m0_rsp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_single_read();
        test_arbitration();
        test_credit_stall();
        test_hol_blocking();
        test_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
